// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared constants and helpers for the demux_stream block.
// Revision : 1.0
// ============================================================================
package demux_pkg;

    localparam int unsigned MAX_OUT = 16;
    localparam logic [MAX_OUT-1:0] ALL_ONES = '1;

    typedef enum logic [0:0] {
        ROUTE_UNICAST = 1'b0,
        ROUTE_BCAST   = 1'b1
    } route_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned v;
        int unsigned r;
        v = (n > 0) ? n - 1 : 0;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Out-of-range selects produce an all-zero mask.
    function automatic logic [MAX_OUT-1:0] onehot(input logic [31:0] sel, input int unsigned n);
        logic [MAX_OUT-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            m[i] = (sel == 32'(i)) && (32'(i) < n);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_if
// Purpose  : Producer-side and consumer-side handshake bundle of demux_stream.
// Revision : 1.0
// ============================================================================
interface demux_stream_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_bcast;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic                   err_sel;
    logic [CNT_W-1:0]       drop_cnt;

    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, err_sel, drop_cnt
    );

    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, err_sel, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/demux_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : demux_onehot_dec
// Purpose  : Turns select + broadcast into a channel mask and a range error.
// Revision : 1.0
// ============================================================================
module demux_onehot_dec
    import demux_pkg::*;
#(
    parameter int N_OUT = 4,
    parameter int SEL_W = 2
) (
    input  wire logic [SEL_W-1:0] sel,
    input  wire logic             bcast,
    output logic      [N_OUT-1:0] mask,
    output logic                  out_of_range
);

    route_e           w_route;
    logic [N_OUT-1:0] w_uni_mask;

    assign w_route    = bcast ? ROUTE_BCAST : ROUTE_UNICAST;
    assign w_uni_mask = N_OUT'(onehot(32'(sel), N_OUT));

    always_comb begin
        mask         = '0;
        out_of_range = 1'b0;
        if (w_route == ROUTE_BCAST) begin
            mask = N_OUT'(ALL_ONES);
        end else begin
            mask         = w_uni_mask;
            out_of_range = (32'(sel) >= 32'(N_OUT));
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream
// Purpose  : 1-to-N_OUT registered demux with per-channel valid/ready and
//            broadcast; drops and counts unicast words with a bad select.
// Revision : 1.0
// ============================================================================
module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  wire logic      clk,
    input  wire logic      reset,
    demux_stream_if.slave  bus
);

    if ((SEL_W < int'(clog2(N_OUT))) || (N_OUT < 2) || (N_OUT > int'(MAX_OUT))) begin : g_param_check
        $error("demux_stream: illegal N_OUT/SEL_W combination");
    end

    logic             r_hold_valid;
    logic [WIDTH-1:0] r_hold_data;
    logic [N_OUT-1:0] r_pend;
    logic             r_err_sel;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [N_OUT-1:0] w_out_valid;
    logic [N_OUT-1:0] w_fire;
    logic             w_done;
    logic             w_in_ready;
    logic             w_accept;
    logic [N_OUT-1:0] w_mask;
    logic             w_oor;

    demux_onehot_dec #(
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_dec (
        .sel          (bus.in_sel),
        .bcast        (bus.in_bcast),
        .mask         (w_mask),
        .out_of_range (w_oor)
    );

    assign w_out_valid = {N_OUT{r_hold_valid}} & r_pend;
    assign w_fire      = w_out_valid & bus.out_ready;
    // The stage frees when every still-owed channel handshakes this cycle.
    assign w_done      = r_hold_valid && ((r_pend & ~w_fire) == '0);
    assign w_in_ready  = !r_hold_valid || w_done;
    assign w_accept    = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_pend       <= '0;
            r_err_sel    <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_err_sel <= 1'b0;
            if (w_accept) begin
                if (w_oor) begin
                    // Consumed but never stored; anything held was retiring now.
                    r_hold_valid <= 1'b0;
                    r_pend       <= '0;
                    r_err_sel    <= 1'b1;
                    if (r_drop_cnt != '1) begin
                        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                    end
                end else begin
                    r_hold_valid <= 1'b1;
                    r_hold_data  <= bus.in_data;
                    r_pend       <= w_mask;
                end
            end else begin
                r_pend <= r_pend & ~w_fire;
                if (w_done) begin
                    r_hold_valid <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_ch
        assign bus.out_data[i*WIDTH +: WIDTH] = w_out_valid[i] ? r_hold_data : '0;
    end

    assign bus.out_valid = w_out_valid;
    assign bus.in_ready  = w_in_ready;
    assign bus.err_sel   = r_err_sel;
    assign bus.drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_stream
// Purpose  : Directed self-checking bench for demux_stream (N_OUT=3, CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_demux_stream;

    localparam int WIDTH = 8;
    localparam int N_OUT = 3;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    demux_stream_if #(
        .WIDTH (WIDTH),
        .N_OUT (N_OUT),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) bus ();

    demux_stream #(
        .WIDTH (WIDTH),
        .N_OUT (N_OUT),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s, input logic b);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.in_bcast = b;
    endtask

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  sel_q;
        logic [7:0]  dat_q;
        logic [23:0] exp_d;
        logic [2:0]  exp_v;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        bus.out_ready = 3'b000;

        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_err_sel", 32'(bus.err_sel), 32'h0);
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Unicast to channel 2
        bus.out_ready = 3'b111;
        drive(1'b1, 8'hA5, 2'd2, 1'b0);
        nedge();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        chk("uni_valid", 32'(bus.out_valid), 32'h4);
        chk("uni_data", 32'(bus.out_data), 32'hA50000);
        nedge();
        chk("uni_after", 32'(bus.out_valid), 32'h0);

        // Backpressure on channel 1; a different word waits meanwhile
        bus.out_ready = 3'b101;
        drive(1'b1, 8'h3C, 2'd1, 1'b0);
        nedge();
        drive(1'b1, 8'h99, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(bus.out_valid), 32'h2);
            chk("bp_data", 32'(bus.out_data), 32'h003C00);
            chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
            nedge();
        end
        bus.out_ready = 3'b111;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'h1);
        nedge();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        chk("bp_next_valid", 32'(bus.out_valid), 32'h1);
        chk("bp_next_data", 32'(bus.out_data), 32'h000099);
        nedge();
        chk("bp_idle", 32'(bus.out_valid), 32'h0);

        // Broadcast with staggered readies
        bus.out_ready = 3'b000;
        drive(1'b1, 8'h77, 2'd0, 1'b1);
        nedge();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        bus.out_ready = 3'b001;
        #1;
        chk("bc_valid0", 32'(bus.out_valid), 32'h7);
        chk("bc_data0", 32'(bus.out_data), 32'h777777);
        chk("bc_ready0", 32'(bus.in_ready), 32'h0);
        nedge();
        bus.out_ready = 3'b100;
        #1;
        chk("bc_valid1", 32'(bus.out_valid), 32'h6);
        chk("bc_data1", 32'(bus.out_data), 32'h777700);
        chk("bc_ready1", 32'(bus.in_ready), 32'h0);
        nedge();
        bus.out_ready = 3'b010;
        #1;
        chk("bc_valid2", 32'(bus.out_valid), 32'h2);
        chk("bc_ready2", 32'(bus.in_ready), 32'h1);
        nedge();
        chk("bc_valid3", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 3'b111;

        // Invalid select drop, then saturate the counter
        drive(1'b1, 8'hFF, 2'd3, 1'b0);
        #1;
        chk("bad_in_ready", 32'(bus.in_ready), 32'h1);
        nedge();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        chk("bad_valid", 32'(bus.out_valid), 32'h0);
        chk("bad_err", 32'(bus.err_sel), 32'h1);
        chk("bad_cnt", 32'(bus.drop_cnt), 32'h1);
        nedge();
        chk("bad_err_clear", 32'(bus.err_sel), 32'h0);
        drive(1'b1, 8'hFF, 2'd3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            nedge();
            chk("sat_err_held", 32'(bus.err_sel), 32'h1);
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        chk("sat_cnt", 32'(bus.drop_cnt), 32'hF);
        chk("sat_valid", 32'(bus.out_valid), 32'h0);
        nedge();
        chk("sat_err_clear", 32'(bus.err_sel), 32'h0);
        chk("sat_cnt_hold", 32'(bus.drop_cnt), 32'hF);

        // Streaming: 8 words, sel 0,1,2,...
        sel_q = 2'd0;
        dat_q = 8'h00;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                exp_v = 3'b001 << sel_q;
                exp_d = 24'(dat_q) << (8 * sel_q);
                chk("str_valid", 32'(bus.out_valid), 32'(exp_v));
                chk("str_data", 32'(bus.out_data), 32'(exp_d));
            end
            if (i < 8) begin
                sel_q = 2'(i % 3);
                dat_q = 8'(8'h10 + i);
                drive(1'b1, dat_q, sel_q, 1'b0);
                #1;
                chk("str_in_ready", 32'(bus.in_ready), 32'h1);
            end else begin
                drive(1'b0, 8'h00, 2'd0, 1'b0);
            end
            nedge();
        end
        chk("str_idle", 32'(bus.out_valid), 32'h0);

        // Async reset while channels 0 and 2 are still owed
        bus.out_ready = 3'b000;
        drive(1'b1, 8'h5A, 2'd0, 1'b1);
        nedge();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        bus.out_ready = 3'b010;
        #1;
        chk("ar_valid0", 32'(bus.out_valid), 32'h7);
        nedge();
        bus.out_ready = 3'b000;
        #1;
        chk("ar_valid1", 32'(bus.out_valid), 32'h5);
        reset = 1'b1;
        #1;
        chk("ar_valid_now", 32'(bus.out_valid), 32'h0);
        chk("ar_data_now", 32'(bus.out_data), 32'h0);
        reset = 1'b0;
        bus.out_ready = 3'b111;
        nedge();
        chk("ar_in_ready", 32'(bus.in_ready), 32'h1);
        chk("ar_valid_after", 32'(bus.out_valid), 32'h0);
        chk("ar_cnt", 32'(bus.drop_cnt), 32'h0);
        nedge();
        chk("ar_no_reappear", 32'(bus.out_data), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
